// File: rtl/gnn_pkg.sv
// gnn_pkg: frame geometry and loader state encoding shared by the feature loader and the aggregator
package gnn_pkg;
  localparam int N_NODES = 4;
  localparam int N_FEAT = 4;
  localparam int BEATS_PER_FRAME = 16;
  localparam int CNT_W = 4;
  typedef enum logic [0:0] {LOAD = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/feat_loader_if.sv
// feat_loader_if: serial feature stream into the loader; FEAT_LOADER_LAST_EN adds in_last_feat
interface feat_loader_if #(parameter int FEAT_W = 5);
  logic in_valid_feat;
  logic in_ready_feat;
  logic [FEAT_W-1:0] in_data_feat;
`ifdef FEAT_LOADER_LAST_EN
  logic in_last_feat;
  modport master(output in_valid_feat, in_data_feat, in_last_feat, input in_ready_feat);
  modport slave(input in_valid_feat, in_data_feat, in_last_feat, output in_ready_feat);
`else
  modport master(output in_valid_feat, in_data_feat, input in_ready_feat);
  modport slave(input in_valid_feat, in_data_feat, output in_ready_feat);
`endif
endinterface

// File: rtl/feat_loader.sv
// feat_loader: serial-to-parallel 4x4 feature frame loader for the aggregator; FEAT_LOADER_LAST_EN adds in_last_feat framing checks with sticky err_frame
module feat_loader
  import gnn_pkg::*;
#(
  parameter int FEAT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  feat_loader_if.slave s,
  input  logic hold_aggr,
  output logic signed [FEAT_W-1:0] x0_n0, x1_n0, x2_n0, x3_n0,
  output logic signed [FEAT_W-1:0] x0_n1, x1_n1, x2_n1, x3_n1,
  output logic signed [FEAT_W-1:0] x0_n2, x1_n2, x2_n2, x3_n2,
  output logic signed [FEAT_W-1:0] x0_n3, x1_n3, x2_n3, x3_n3,
  output logic out_ready_aggr,
`ifdef FEAT_LOADER_LAST_EN
  output logic err_frame,
`endif
  output logic busy
);
  localparam int BEATS = N_NODES * N_FEAT;
  localparam logic [0:0] ST_LOAD = LOAD;
  localparam logic [0:0] ST_FULL = FULL;
  logic [0:0] state;
  logic [CNT_W-1:0] cnt;
  logic [FEAT_W-1:0] sh [BEATS];
  logic [FEAT_W-1:0] xr [BEATS];
  logic acc, last_beat, issue, drop;
  assign s.in_ready_feat = state == ST_LOAD;
  assign acc = s.in_valid_feat && s.in_ready_feat;
  assign last_beat = acc && cnt == CNT_W'(BEATS_PER_FRAME - 1);
`ifdef FEAT_LOADER_LAST_EN
  assign drop = acc && s.in_last_feat && !last_beat;
`else
  assign drop = 1'b0;
`endif
  assign issue = !hold_aggr && (last_beat || state == ST_FULL);
  assign busy = cnt != '0 || state == ST_FULL;
  always_ff @(posedge clk)
    if (acc) sh[cnt] <= s.in_data_feat;
  // the final beat bypasses the shadow so an unheld frame issues on the edge it completes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_LOAD;
      cnt <= '0;
      out_ready_aggr <= 1'b0;
      for (int k = 0; k < BEATS; k++) xr[k] <= '0;
    end else begin
      out_ready_aggr <= issue;
      if (issue)
        for (int k = 0; k < BEATS; k++) xr[k] <= (acc && cnt == CNT_W'(k)) ? s.in_data_feat : sh[k];
      cnt <= drop ? '0 : cnt + CNT_W'(acc);
      state <= issue ? ST_LOAD : last_beat ? ST_FULL : state;
    end
`ifdef FEAT_LOADER_LAST_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_frame <= 1'b0;
    else if (drop || (last_beat && !s.in_last_feat)) err_frame <= 1'b1;
`endif
  assign {x3_n0, x2_n0, x1_n0, x0_n0} = {xr[3], xr[2], xr[1], xr[0]};
  assign {x3_n1, x2_n1, x1_n1, x0_n1} = {xr[7], xr[6], xr[5], xr[4]};
  assign {x3_n2, x2_n2, x1_n2, x0_n2} = {xr[11], xr[10], xr[9], xr[8]};
  assign {x3_n3, x2_n3, x1_n3, x0_n3} = {xr[15], xr[14], xr[13], xr[12]};
endmodule

// File: tb/tb_feat_loader.sv
// tb_feat_loader: randomized scoreboard bench for feat_loader; covers FEAT_LOADER_LAST_EN when defined
module tb_feat_loader;
  localparam int W = 5;
  logic clk = 0, rst_n = 0, hold = 0;
  always #5 clk = ~clk;
  feat_loader_if #(.FEAT_W(W)) s ();
  logic [W-1:0] x0_n0, x1_n0, x2_n0, x3_n0, x0_n1, x1_n1, x2_n1, x3_n1;
  logic [W-1:0] x0_n2, x1_n2, x2_n2, x3_n2, x0_n3, x1_n3, x2_n3, x3_n3;
  logic ordy, busy;
`ifdef FEAT_LOADER_LAST_EN
  logic err;
  bit last_in = 0;
`endif
  feat_loader #(.FEAT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .hold_aggr(hold),
    .x0_n0(x0_n0), .x1_n0(x1_n0), .x2_n0(x2_n0), .x3_n0(x3_n0),
    .x0_n1(x0_n1), .x1_n1(x1_n1), .x2_n1(x2_n1), .x3_n1(x3_n1),
    .x0_n2(x0_n2), .x1_n2(x1_n2), .x2_n2(x2_n2), .x3_n2(x3_n2),
    .x0_n3(x0_n3), .x1_n3(x1_n3), .x2_n3(x2_n3), .x3_n3(x3_n3),
    .out_ready_aggr(ordy),
`ifdef FEAT_LOADER_LAST_EN
    .err_frame(err),
`endif
    .busy(busy)
  );
  wire [16*W-1:0] xo = {x3_n3, x2_n3, x1_n3, x0_n3, x3_n2, x2_n2, x1_n2, x0_n2,
                        x3_n1, x2_n1, x1_n1, x0_n1, x3_n0, x2_n0, x1_n0, x0_n0};
  int tests = 0, fails = 0, cyc_n = 0;
  logic [W-1:0] bq [$];
  logic [16*W-1:0] exp_q [$];
  logic [16*W-1:0] cur = '0;
  bit pend = 0, exp_err = 0;
  int strobes [$];
  always @(posedge clk) cyc_n++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [16*W-1:0] pack_frame();
    logic [16*W-1:0] f = '0;
    for (int k = 0; k < 16; k++) f[k*W +: W] = bq[k];
    return f;
  endfunction

  // reference: collect accepted beats; a complete frame issues on the first edge with hold low
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit h = 0);
    bit r;
    @(negedge clk);
    s.in_valid_feat = v;
    s.in_data_feat = d;
    hold = h;
`ifdef FEAT_LOADER_LAST_EN
    s.in_last_feat = last_in;
`endif
    r = !pend;
    chk("in_ready", s.in_ready_feat, r);
    @(posedge clk);
    if (v && r) begin
`ifdef FEAT_LOADER_LAST_EN
      if (last_in && bq.size() < 15) begin
        bq.delete();
        exp_err = 1;
      end else begin
        bq.push_back(d);
        if (bq.size() == 16 && !last_in) exp_err = 1;
      end
`else
      bq.push_back(d);
`endif
      if (bq.size() == 16) pend = 1;
    end
    if (pend && !h) begin
      exp_q.push_back(pack_frame());
      bq.delete();
      pend = 0;
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("strobe", ordy, exp_q.size() != 0);
    if (ordy) strobes.push_back(cyc_n);
    if (exp_q.size() != 0) cur = exp_q.pop_front();
    chk("x_out", xo, cur);
    chk("busy", busy, bq.size() != 0 || pend);
`ifdef FEAT_LOADER_LAST_EN
    chk("err_frame", err, exp_err);
`endif
  end

  task automatic flush();
    for (int i = 0; i < 40 && (bq.size() != 0 || pend); i++) cyc(1, W'($urandom));
    cyc(0, 0);
  endtask

  initial begin
    int n;
    s.in_valid_feat = 0;
    s.in_data_feat = 0;
`ifdef FEAT_LOADER_LAST_EN
    s.in_last_feat = 0;
`endif
    @(posedge clk);
    #1;
    chk("rst_x", xo, 0);
    chk("rst_strobe", ordy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s.in_ready_feat, 1);
    @(negedge clk) rst_n = 1;
    // ramp frame
    for (int k = 0; k < 16; k++) cyc(1, W'(k));
    cyc(0, 0);
    chk("x0_n0", x0_n0, 0);
    chk("x3_n0", x3_n0, 3);
    chk("x0_n3", x0_n3, 12);
    chk("x3_n3", x3_n3, 15);
    // signed extremes, continuous valid
    for (int k = 0; k < 16; k++) cyc(1, 5'b10000);
    for (int k = 0; k < 16; k++) cyc(1, 5'b01111);
    cyc(0, 0);
    cyc(0, 0);
    n = strobes.size();
    chk("strobe_gap", strobes[n-1] - strobes[n-2], 16);
    chk("x_min_max", {x3_n3, x0_n0}, {5'b01111, 5'b01111});
    // hold across the last beat
    for (int k = 0; k < 15; k++) cyc(1, W'($urandom));
    cyc(1, W'($urandom), 1);
    for (int k = 0; k < 5; k++) cyc(1, W'($urandom), 1);
    cyc(1, W'($urandom), 0);
    for (int k = 0; k < 16; k++) cyc(1, W'($urandom));
    cyc(0, 0);
    // random gaps and holds
    for (int i = 0; i < 300; i++) cyc(1'($urandom % 2), W'($urandom), $urandom % 5 == 0);
    flush();
    // reset mid-frame
    for (int k = 0; k < 8; k++) cyc(1, W'(k + 3));
    @(negedge clk);
    s.in_valid_feat = 0;
    rst_n = 0;
    #1;
    chk("midrst_x", xo, 0);
    chk("midrst_strobe", ordy, 0);
    chk("midrst_busy", busy, 0);
    bq.delete();
    exp_q.delete();
    pend = 0;
    cur = '0;
    exp_err = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 16; k++) cyc(1, W'($urandom));
    cyc(0, 0);
`ifdef FEAT_LOADER_LAST_EN
    for (int k = 0; k < 10; k++) begin
      last_in = k == 9;
      cyc(1, W'($urandom));
    end
    last_in = 0;
    cyc(0, 0);
    chk("early_last_err", err, 1);
    for (int k = 0; k < 16; k++) begin
      last_in = k == 15;
      cyc(1, W'($urandom));
    end
    last_in = 0;
    cyc(0, 0);
    chk("err_sticky", err, 1);
`endif
    cyc(0, 0);
    cyc(0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/feat_loader.md
Name: feat_loader

Overview:
- Producer for the aggregation stage's parallel input interface.
- Accepts node features as a serial valid/ready stream, one signed feature per beat, node-major order.
- Assembles a full 4-node x 4-feature frame in a shadow buffer.
- Presents all 16 values in parallel on registered outputs, with a one-cycle out_ready_aggr strobe, exactly as the aggregator samples them.
- Honors a hold input from downstream.

Parameters:
- FEAT_W, 5, signed feature width; must equal the aggregator input width.
- N_NODES, 4, nodes per frame; fixed, not overridable in this revision.
- N_FEAT, 4, features per node; fixed, not overridable in this revision.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid_feat  input  1  upstream beat valid.
- in_ready_feat  output  1  loader can accept a beat.
- in_data_feat  input  FEAT_W  signed feature beat.
- hold_aggr  input  1  downstream not ready for a new frame; blocks issue.
- x{f}_n{n}  output  FEAT_W  16 signed parallel outputs, f,n in 0..3, registered.
- out_ready_aggr  output  1  one-cycle strobe; outputs valid in that cycle.
- busy  output  1  high while a frame is partially or fully loaded but not yet issued.

Behaviour:
- Reset (async assert, sync release): all x*_n* = 0, out_ready_aggr = 0, in_ready_feat = 1, busy = 0, beat counter = 0, state LOAD, shadow contents don't-care.
- A beat is accepted when in_valid_feat && in_ready_feat at a rising edge.
- Beat k (0..15) maps to feature f = k mod 4, node n = k div 4; it is written to shadow[n][f].
- Data is passed bit-exact; no arithmetic, no sign extension.
- States:
  - LOAD: in_ready_feat = 1. Each accepted beat increments the counter.
  - LOAD, beat 15 accepted, hold_aggr = 0: at that same edge, copy shadow plus the current beat into the output registers, set out_ready_aggr = 1 for exactly one cycle, counter -> 0, stay in LOAD.
  - LOAD, beat 15 accepted, hold_aggr = 1: store the beat, go to FULL.
  - FULL: in_ready_feat = 0.
  - FULL, hold_aggr = 0 at an edge: copy to outputs, pulse out_ready_aggr, counter -> 0, go to LOAD. in_ready_feat returns to 1 in the same cycle the strobe is high.
- Latency: last beat accepted at edge t, so outputs and strobe are visible in the cycle after t, when unheld.
- hold_aggr is only sampled at issue decisions; it never stalls partial loading.
- Outputs hold their last issued frame until the next issue. No output changes without a strobe.
- Back-to-back frames: 16 beats per frame, so sustained throughput is one frame per 16 cycles. Strobes are never adjacent.
- busy = (counter != 0) || state == FULL.
- in_ready_feat is a registered or pure state decode; it has no combinational path from in_valid_feat.
- Reset mid-frame discards the partial frame. The output registers are cleared to 0.

Optional Feature:
- FEAT_LOADER_LAST_EN.
- Defined:
  - Adds input in_last_feat (1 bit, qualifies the beat) and output err_frame (1 bit, sticky, cleared only by reset).
  - in_last_feat on beat k < 15: drop the partial frame, counter -> 0, no strobe, set err_frame.
  - Beat 15 without in_last_feat: frame still issued normally, set err_frame.
- Undefined: neither port exists; frame boundaries come purely from the counter.

Decomposition:
- Shared package gnn_pkg: N_NODES, N_FEAT, BEATS_PER_FRAME = 16, counter width 4, state enum {LOAD, FULL}.
- No sub-module. The shadow array, counter and FSM fit in one module.
- The aggregator and this loader both import gnn_pkg.

Test Plan:
- Reset, then stream beats 0..15 with values 0..15 (n0: 0..3, n1: 4..7, and so on) -> one strobe the cycle after beat 15; x0_n0 = 0, x3_n0 = 3, x0_n3 = 12, x3_n3 = 15.
- Signed extremes: all beats -16 then all beats +15 (FEAT_W = 5) -> both frames issued bit-exact, two strobes exactly 16 cycles apart with continuous valid.
- hold_aggr = 1 across the last beat for 5 cycles -> in_ready_feat low for those cycles, outputs unchanged; strobe one cycle after hold drops; next beat accepted in the strobe cycle.
- Random in_valid_feat gaps (50%) -> frames complete correctly; outputs change only on strobe cycles.
- rst_n asserted after beat 7 -> outputs 0 immediately, no strobe; a full new frame then issues correctly.
- FEAT_LOADER_LAST_EN: in_last_feat on beat 9 -> no strobe, err_frame = 1; the following clean 16-beat frame issues with err_frame still 1.
